l2cache_axi_bridge: RTL and testbench
=====================================

Name: l2cache_axi_bridge

Overview:
Memory-side adapter between the L2 cache mem port and a single AXI4 master interface (32-bit data). Converts L2 line refills into INCR read bursts and L2 dirty-line write-backs into INCR write bursts. Uncached (SUC) accesses become single-beat transfers. Read and write channels run independently, with one outstanding transaction per direction.

Parameters:
OFFSET_WIDTH, 3, log2(words per L2 line); line = 32<<OFFSET_WIDTH bits, burst = 1<<OFFSET_WIDTH beats.
LINE_W, 32*(1<<OFFSET_WIDTH), line width (derived; do not override).

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
l2_addr_r  in  32  read address (line-aligned unless l2_suc)
l2_addr_w  in  32  write address (line-aligned unless l2_suc)
l2_req_r  in  1  read request
l2_req_w  in  1  write request
l2_rdy  in  1  L2 can accept returned read data this cycle
l2_suc  in  1  uncached single access
l2_wstrb  in  4  byte strobe (SUC write)
l2_size  in  2  AXI size (SUC only; line = 2)
l2_wline  in  LINE_W  write line; SUC uses [31:0]
l2_rline  out  LINE_W  read line; SUC returns data in [31:0], upper bits 0
l2_addrok_r  out  1  read request accepted
l2_addrok_w  out  1  write request accepted (data captured)
l2_dataok  out  1  read data valid
araddr  out 32; arlen out 8; arsize out 3; arburst out 2; arvalid out 1; arready in 1
rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1
awaddr out 32; awlen out 8; awsize out 3; awburst out 2; awvalid out 1; awready in 1
wdata out 32; wstrb out 4; wlast out 1; wvalid out 1; wready in 1
bresp in 2; bvalid in 1; bready out 1
bus_err  out  1  sticky; set on any rresp/bresp != OKAY

Behaviour:
- Reset: synchronous, active-low. Both FSMs go to IDLE. All valid, ready and ok outputs are 0. l2_rline = 0, bus_err = 0, beat counters = 0.
- Fixed fields: burst = 2'b01 (INCR). Line access: len = (1<<OFFSET_WIDTH)-1, size = 3'd2. SUC access: len = 0, size = l2_size, address passed unaligned.
- Read FSM states: R_IDLE, R_AR, R_DATA, R_DONE.
  - R_IDLE:
    - If l2_req_r and no write hazard: l2_addrok_r = 1 (combinational, same cycle). Latch addr and suc, clear l2_rline and the beat counter, then go to R_AR.
    - Hazard = write FSM not in W_IDLE and latched write line address [31:OFFSET_WIDTH+2] equals l2_addr_r [31:OFFSET_WIDTH+2]. While the hazard holds, l2_addrok_r = 0.
  - R_AR: arvalid = 1 until arready; then go to R_DATA.
  - R_DATA:
    - rready = 1. Each rvalid beat writes rdata into word[cnt] of l2_rline (word 0 for SUC), then cnt++.
    - On the rvalid && rlast beat, go to R_DONE.
    - Beat count is not cross-checked against rlast; rlast is authoritative.
  - R_DONE: l2_dataok = l2_rdy. When l2_rdy = 1, pulse l2_dataok for exactly one cycle and return to R_IDLE. l2_rline stays stable until the next accept.
- Write FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE: if l2_req_w, l2_addrok_w = 1 same cycle. Latch addr, line, wstrb, size and suc; clear cnt and aw_done; go to W_ADDR_DATA.
  - W_ADDR_DATA:
    - awvalid = !aw_done; aw_done is set on awready.
    - wvalid = 1 in parallel (no wait for awready).
    - wdata = word[cnt]. wstrb = 4'hF for a line, latched wstrb for SUC. wlast = (cnt == len).
    - Each wvalid && wready beat increments cnt.
    - Leave for W_RESP once the wlast beat has handshaken and the AW handshake is done (current cycle or earlier).
  - W_RESP: bready = 1. On bvalid, go to W_IDLE; l2_req_w can be accepted again from the following cycle.
- Writes are posted: L2 receives no completion signal beyond l2_addrok_w. l2_addrok_w stays 0 while the write FSM is busy.
- Simultaneous l2_req_r and l2_req_w: both are accepted in the same cycle when there is no hazard. The hazard check uses the write FSM state before that cycle, so a read and write issued together are both accepted.
- Reset mid-burst: FSMs abort to IDLE immediately. The whole SoC resets together, so the AXI protocol break is acceptable.
- bus_err is set on (rvalid && rresp != 0) or (bvalid && bresp != 0) and is cleared only by reset. Data is passed through unchanged on error.

Decomposition:
- Shared package l2cache_axi_pkg:
  - AXI_BURST_INCR, AXI_RESP_OKAY.
  - Read/write state encodings.
  - LINE_WORDS = 1<<OFFSET_WIDTH.
- Natural sub-module: l2cache_axi_wchan (write FSM plus line buffer). It exports its busy flag and latched line address for the read-side hazard check. The read FSM stays in the top.

Test Plan:
1. Line read at 0x1C00_0040; slave returns beats 0x11..0x88 with arready delayed 2 cycles -> araddr=0x1C000040, arlen=7, arsize=2; l2_rline word0=0x11 … word7=0x88; one-cycle l2_dataok.
2. SUC byte read at 0x1FE0_01E5 with size=0 -> arlen=0, arsize=0, araddr=0x1FE001E5; l2_rline[31:0]=rdata, rest 0.
3. Line write to 0x0000_1000 with awready after 3 cycles and wready toggling -> wvalid asserted in the first W_ADDR_DATA cycle; 8 beats in order; wlast only on beat 8; l2_addrok_w=0 until bvalid has been consumed.
4. Write to line 0x2000 pending (bvalid held off), then l2_req_r to 0x2010 -> l2_addrok_r=0 until the cycle after bvalid; a read to 0x3000 meanwhile is accepted immediately.
5. Read complete with l2_rdy=0 for 4 cycles -> l2_dataok stays 0 and l2_rline is stable; l2_dataok pulses the cycle l2_rdy=1.
6. rstn low at beat 3 of a read burst -> next cycle rready=0, arvalid=0, FSM in R_IDLE; bresp=2'b10 on a later write sets bus_err, which persists until reset.

Source files
------------

// File: rtl/l2cache_axi_pkg.sv
// Shared constants for the L2 cache <-> AXI4 bridge.
//   AXI_BURST_INCR / AXI_RESP_OKAY : AXI field encodings
//   R_* / W_*                      : read / write FSM state encodings
//   line_words()                   : words per L2 line for a given offset width
package l2cache_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_ADDR_DATA = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;

  // LINE_WORDS = 1 << OFFSET_WIDTH
  function automatic int unsigned line_words(input int unsigned offset_width);
    return 32'd1 << offset_width;
  endfunction

endpackage

// File: rtl/l2cache_axi_bridge_if.sv
// AXI4 (32-bit data) bus between the L2 bridge and the memory system.
//   master : bridge side (drives AR/AW/W, rready, bready)
//   slave  : memory side (drives arready/awready/wready, R and B channels)
interface l2cache_axi_bridge_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/l2cache_axi_wchan.sv
// Write channel of the L2 bridge: captures a write-back line (or SUC word) on
// accept and issues it as one AXI INCR burst, AW and W in parallel.
//   l2_*           : L2 write request side (l2_addrok_w = accepted this cycle)
//   busy, line_tag : state/line address for the read-side hazard check
//   aw*, w*, b*    : AXI write address / data / response handshakes
module l2cache_axi_wchan import l2cache_axi_pkg::*; #(
  parameter int unsigned OFFSET_WIDTH = 3,
  parameter int unsigned LINE_W       = 32 * (1 << OFFSET_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              l2_addr_w,
  input  logic                     l2_req_w,
  input  logic                     l2_suc,
  input  logic [3:0]               l2_wstrb,
  input  logic [1:0]               l2_size,
  input  logic [LINE_W-1:0]        l2_wline,
  output logic                     l2_addrok_w,
  output logic                     busy,
  output logic [31:OFFSET_WIDTH+2] line_tag,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);
  localparam int unsigned LINE_WORDS = line_words(OFFSET_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] LAST_CNT = OFFSET_WIDTH'(LINE_WORDS - 1);

  logic [1:0]              state_q;
  logic [31:0]             addr_q;
  logic [LINE_W-1:0]       line_q;
  logic [3:0]              strb_q;
  logic [1:0]              size_q;
  logic                    suc_q;
  logic [OFFSET_WIDTH-1:0] cnt_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic                    aw_hs, w_hs, aw_ok, w_ok;

  always_comb begin
    l2_addrok_w = (state_q == W_IDLE) && l2_req_w;
    busy        = (state_q != W_IDLE);
    line_tag    = addr_q[31:OFFSET_WIDTH+2];
    awaddr      = addr_q;
    awlen       = suc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    awsize      = suc_q ? {1'b0, size_q} : 3'd2;
    awburst     = AXI_BURST_INCR;
    awvalid     = (state_q == W_ADDR_DATA) && !aw_done_q;
    // W does not wait for AW; it stops once the last beat has gone.
    wvalid      = (state_q == W_ADDR_DATA) && !w_done_q;
    wlast       = suc_q || (cnt_q == LAST_CNT);
    wstrb       = suc_q ? strb_q : 4'hF;
    bready      = (state_q == W_RESP);
    wdata       = '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      if (cnt_q == i[OFFSET_WIDTH-1:0]) wdata = line_q[i*32 +: 32];
    end
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    aw_ok = aw_done_q || aw_hs;
    w_ok  = w_done_q || (w_hs && wlast);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      line_q    <= '0;
      strb_q    <= '0;
      size_q    <= '0;
      suc_q     <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        W_IDLE: if (l2_req_w) begin
          addr_q    <= l2_addr_w;
          line_q    <= l2_wline;
          strb_q    <= l2_wstrb;
          size_q    <= l2_size;
          suc_q     <= l2_suc;
          cnt_q     <= '0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= W_ADDR_DATA;
        end
        W_ADDR_DATA: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) begin
            cnt_q <= cnt_q + 1'b1;
            if (wlast) w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) state_q <= W_RESP;
        end
        W_RESP: if (bvalid) state_q <= W_IDLE;
        default: state_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/l2cache_axi_bridge.sv
// L2 cache mem port to AXI4 master bridge. Line refills become INCR read
// bursts, dirty write-backs INCR write bursts, SUC accesses single beats.
// One outstanding transaction per direction.
//   l2_*    : L2 request/response side (l2_rline valid while l2_dataok)
//   axi     : AXI4 master port
//   bus_err : sticky, set on any non-OKAY rresp/bresp
module l2cache_axi_bridge import l2cache_axi_pkg::*; #(
  parameter int unsigned OFFSET_WIDTH = 3,
  parameter int unsigned LINE_W       = 32 * (1 << OFFSET_WIDTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        l2_addr_r,
  input  logic [31:0]        l2_addr_w,
  input  logic               l2_req_r,
  input  logic               l2_req_w,
  input  logic               l2_rdy,
  input  logic               l2_suc,
  input  logic [3:0]         l2_wstrb,
  input  logic [1:0]         l2_size,
  input  logic [LINE_W-1:0]  l2_wline,
  output logic [LINE_W-1:0]  l2_rline,
  output logic               l2_addrok_r,
  output logic               l2_addrok_w,
  output logic               l2_dataok,
  l2cache_axi_bridge_if.master axi,
  output logic               bus_err
);
  localparam int unsigned LINE_WORDS = line_words(OFFSET_WIDTH);

  logic [1:0]              r_state_q;
  logic [31:0]             r_addr_q;
  logic                    r_suc_q;
  logic [1:0]              r_size_q;
  logic [OFFSET_WIDTH-1:0] r_cnt_q;
  logic [OFFSET_WIDTH-1:0] r_idx;
  logic [LINE_W-1:0]       rline_q;
  logic                    bus_err_q;
  logic                    w_busy;
  logic [31:OFFSET_WIDTH+2] w_tag;
  logic                    hazard;

  l2cache_axi_wchan #(
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .LINE_W       (LINE_W)
  ) u_wchan (
    .clk         (clk),
    .rstn        (rstn),
    .l2_addr_w   (l2_addr_w),
    .l2_req_w    (l2_req_w),
    .l2_suc      (l2_suc),
    .l2_wstrb    (l2_wstrb),
    .l2_size     (l2_size),
    .l2_wline    (l2_wline),
    .l2_addrok_w (l2_addrok_w),
    .busy        (w_busy),
    .line_tag    (w_tag),
    .awaddr      (axi.awaddr),
    .awlen       (axi.awlen),
    .awsize      (axi.awsize),
    .awburst     (axi.awburst),
    .awvalid     (axi.awvalid),
    .awready     (axi.awready),
    .wdata       (axi.wdata),
    .wstrb       (axi.wstrb),
    .wlast       (axi.wlast),
    .wvalid      (axi.wvalid),
    .wready      (axi.wready),
    .bvalid      (axi.bvalid),
    .bready      (axi.bready)
  );

  always_comb begin
    // Uses the registered write state, so a read and write issued together
    // are both accepted.
    hazard      = w_busy && (w_tag == l2_addr_r[31:OFFSET_WIDTH+2]);
    l2_addrok_r = (r_state_q == R_IDLE) && l2_req_r && !hazard;
    l2_dataok   = (r_state_q == R_DONE) && l2_rdy;
    l2_rline    = rline_q;
    bus_err     = bus_err_q;
    r_idx       = r_suc_q ? '0 : r_cnt_q;
    axi.araddr  = r_addr_q;
    axi.arlen   = r_suc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    axi.arsize  = r_suc_q ? {1'b0, r_size_q} : 3'd2;
    axi.arburst = AXI_BURST_INCR;
    axi.arvalid = (r_state_q == R_AR);
    axi.rready  = (r_state_q == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_suc_q   <= 1'b0;
      r_size_q  <= '0;
      r_cnt_q   <= '0;
      rline_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: if (l2_addrok_r) begin
          r_addr_q  <= l2_addr_r;
          r_suc_q   <= l2_suc;
          r_size_q  <= l2_size;
          r_cnt_q   <= '0;
          rline_q   <= '0;
          r_state_q <= R_AR;
        end
        R_AR: if (axi.arready) r_state_q <= R_DATA;
        R_DATA: if (axi.rvalid) begin
          for (int i = 0; i < int'(LINE_WORDS); i++) begin
            if (r_idx == i[OFFSET_WIDTH-1:0]) rline_q[i*32 +: 32] <= axi.rdata;
          end
          r_cnt_q <= r_cnt_q + 1'b1;
          // rlast ends the burst regardless of the beat count.
          if (axi.rlast) r_state_q <= R_DONE;
        end
        R_DONE: if (l2_rdy) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus_err_q <= 1'b0;
    end else if ((axi.rvalid && axi.rresp != AXI_RESP_OKAY) ||
                 (axi.bvalid && axi.bresp != AXI_RESP_OKAY)) begin
      bus_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l2cache_axi_bridge.sv
// Directed self-checking bench for l2cache_axi_bridge (OFFSET_WIDTH = 3).
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later.
module tb_l2cache_axi_bridge;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   l2_addr_r, l2_addr_w;
  logic          l2_req_r, l2_req_w, l2_rdy, l2_suc;
  logic [3:0]    l2_wstrb;
  logic [1:0]    l2_size;
  logic [LW-1:0] l2_wline, l2_rline;
  logic          l2_addrok_r, l2_addrok_w, l2_dataok, bus_err;
  int            n_cmp = 0;
  int            n_err = 0;

  l2cache_axi_bridge_if axi ();

  l2cache_axi_bridge #(.OFFSET_WIDTH(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .l2_addr_r   (l2_addr_r),
    .l2_addr_w   (l2_addr_w),
    .l2_req_r    (l2_req_r),
    .l2_req_w    (l2_req_w),
    .l2_rdy      (l2_rdy),
    .l2_suc      (l2_suc),
    .l2_wstrb    (l2_wstrb),
    .l2_size     (l2_size),
    .l2_wline    (l2_wline),
    .l2_rline    (l2_rline),
    .l2_addrok_r (l2_addrok_r),
    .l2_addrok_w (l2_addrok_w),
    .l2_dataok   (l2_dataok),
    .axi         (axi),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l2_addr_r = '0; l2_addr_w = '0; l2_req_r = 0; l2_req_w = 0; l2_rdy = 0; l2_suc = 0;
    l2_wstrb = '0; l2_size = '0; l2_wline = '0;
    axi.arready = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = '0; axi.bvalid = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    tick();
    tick();
    rstn = 1;
    #1;
    n_cmp++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, l2_dataok,
         l2_addrok_r, l2_addrok_w} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000", {axi.arvalid, axi.rready,
               axi.awvalid, axi.wvalid, axi.bready, l2_dataok, l2_addrok_r, l2_addrok_w});
    end
    n_cmp++;
    if (l2_rline !== '0) begin n_err++; $display("FAIL reset_rline: got %h want 0", l2_rline); end
    n_cmp++;
    if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_line_read();
    logic [LW-1:0] exp;
    exp = '0;
    l2_rdy = 1; l2_suc = 0; l2_addr_r = 32'h1C00_0040; l2_req_r = 1;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b1) begin n_err++; $display("FAIL rd_accept: got %b want 1", l2_addrok_r); end
    tick();
    l2_req_r = 0;
    #1;
    n_cmp++;
    if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} !==
        {1'b1, 32'h1C00_0040, 8'd7, 3'd2, 2'b01}) begin
      n_err++;
      $display("FAIL rd_ar_fields: got v=%b a=%h len=%0d size=%0d burst=%b want v=1 a=1c000040 len=7 size=2 burst=01",
               axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst);
    end
    tick();
    tick();
    n_cmp++;
    if (axi.arvalid !== 1'b1) begin n_err++; $display("FAIL rd_ar_hold: got %b want 1", axi.arvalid); end
    axi.arready = 1;
    tick();
    axi.arready = 0;
    #1;
    n_cmp++;
    if ({axi.arvalid, axi.rready} !== 2'b01) begin
      n_err++; $display("FAIL rd_data_phase: got arvalid,rready=%b want 01", {axi.arvalid, axi.rready});
    end
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1; axi.rlast = (i == 7); axi.rdata = 32'(32'h11 * (i + 1));
      exp[i*32 +: 32] = 32'(32'h11 * (i + 1));
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    n_cmp++;
    if (l2_dataok !== 1'b1) begin n_err++; $display("FAIL rd_dataok: got %b want 1", l2_dataok); end
    n_cmp++;
    if (l2_rline !== exp) begin n_err++; $display("FAIL rd_line: got %h want %h", l2_rline, exp); end
    tick();
    n_cmp++;
    if (l2_dataok !== 1'b0) begin n_err++; $display("FAIL rd_dataok_pulse: got %b want 0", l2_dataok); end
  endtask

  task automatic test_suc_read();
    l2_suc = 1; l2_size = 2'd0; l2_addr_r = 32'h1FE0_01E5; l2_req_r = 1;
    tick();
    l2_req_r = 0; l2_suc = 0;
    #1;
    n_cmp++;
    if ({axi.araddr, axi.arlen, axi.arsize} !== {32'h1FE0_01E5, 8'd0, 3'd0}) begin
      n_err++;
      $display("FAIL suc_ar_fields: got a=%h len=%0d size=%0d want a=1fe001e5 len=0 size=0",
               axi.araddr, axi.arlen, axi.arsize);
    end
    axi.arready = 1;
    tick();
    axi.arready = 0; axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'hCAFE_00E5;
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    n_cmp++;
    if ({l2_dataok, l2_rline} !== {1'b1, 224'b0, 32'hCAFE_00E5}) begin
      n_err++; $display("FAIL suc_rline: got ok=%b line=%h want ok=1 line=...cafe00e5", l2_dataok, l2_rline);
    end
    tick();
  endtask

  task automatic test_line_write();
    int b;
    for (int i = 0; i < 8; i++) l2_wline[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    l2_suc = 0; l2_addr_w = 32'h0000_1000; l2_req_w = 1;
    #1;
    n_cmp++;
    if (l2_addrok_w !== 1'b1) begin n_err++; $display("FAIL wr_accept: got %b want 1", l2_addrok_w); end
    tick();
    n_cmp++;
    if ({axi.wvalid, axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wstrb} !==
        {2'b11, 32'h1000, 8'd7, 3'd2, 2'b01, 4'hF}) begin
      n_err++;
      $display("FAIL wr_first_cycle: got wv=%b awv=%b a=%h len=%0d size=%0d burst=%b strb=%h",
               axi.wvalid, axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wstrb);
    end
    b = 0;
    for (int c = 0; c < 40 && b < 8; c++) begin
      axi.awready = (c == 3); axi.wready = (c % 2 == 1);
      #1;
      if (axi.wvalid && axi.wready) begin
        n_cmp++;
        if ({axi.wdata, axi.wlast} !== {32'hA000_0000 + 32'(b), b == 7}) begin
          n_err++;
          $display("FAIL wr_beat%0d: got data=%h last=%b want data=%h last=%b", b, axi.wdata,
                   axi.wlast, 32'hA000_0000 + 32'(b), b == 7);
        end
        b++;
      end
      n_cmp++;
      if (l2_addrok_w !== 1'b0) begin n_err++; $display("FAIL wr_busy_ok: got %b want 0", l2_addrok_w); end
      tick();
    end
    axi.awready = 0; axi.wready = 0;
    n_cmp++;
    if (b != 8) begin n_err++; $display("FAIL wr_beats_timeout: got %0d beats want 8", b); end
    #1;
    n_cmp++;
    if ({axi.bready, axi.wvalid, axi.awvalid, l2_addrok_w} !== 4'b1000) begin
      n_err++; $display("FAIL wr_resp_state: got %b want 1000",
                        {axi.bready, axi.wvalid, axi.awvalid, l2_addrok_w});
    end
    tick();
    axi.bvalid = 1;
    #1;
    n_cmp++;
    if (l2_addrok_w !== 1'b0) begin n_err++; $display("FAIL wr_ok_during_b: got %b want 0", l2_addrok_w); end
    tick();
    axi.bvalid = 0;
    #1;
    n_cmp++;
    if (l2_addrok_w !== 1'b1) begin n_err++; $display("FAIL wr_ok_after_b: got %b want 1", l2_addrok_w); end
    l2_req_w = 0;
    #1;
  endtask

  task automatic test_hazard();
    int k;
    l2_suc = 0; l2_rdy = 1; l2_addr_w = 32'h0000_2000; l2_req_w = 1;
    tick();
    l2_req_w = 0; axi.awready = 1; axi.wready = 1;
    k = 0;
    while (!axi.bready && k < 20) begin tick(); k++; end
    axi.awready = 0; axi.wready = 0;
    n_cmp++;
    if (axi.bready !== 1'b1) begin n_err++; $display("FAIL hz_wr_timeout: got bready=%b want 1", axi.bready); end
    l2_addr_r = 32'h0000_2010; l2_req_r = 1;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b0) begin n_err++; $display("FAIL hz_block: got %b want 0", l2_addrok_r); end
    tick();
    n_cmp++;
    if (l2_addrok_r !== 1'b0) begin n_err++; $display("FAIL hz_block_hold: got %b want 0", l2_addrok_r); end
    l2_addr_r = 32'h0000_3000;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b1) begin n_err++; $display("FAIL hz_other_line: got %b want 1", l2_addrok_r); end
    tick();
    l2_req_r = 0; axi.arready = 1;
    tick();
    axi.arready = 0; axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'h1;
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    n_cmp++;
    if (l2_dataok !== 1'b1) begin n_err++; $display("FAIL hz_other_done: got %b want 1", l2_dataok); end
    tick();
    l2_addr_r = 32'h0000_2010; l2_req_r = 1; axi.bvalid = 1;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b0) begin n_err++; $display("FAIL hz_block_bvalid: got %b want 0", l2_addrok_r); end
    tick();
    axi.bvalid = 0;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b1) begin n_err++; $display("FAIL hz_release: got %b want 1", l2_addrok_r); end
    l2_req_r = 0;
    #1;
  endtask

  task automatic test_back_to_back();
    int k;
    l2_rdy = 1; l2_suc = 0; l2_addr_r = 32'h6000; l2_addr_w = 32'h6000; l2_req_r = 1; l2_req_w = 1;
    #1;
    n_cmp++;
    if ({l2_addrok_r, l2_addrok_w} !== 2'b11) begin
      n_err++; $display("FAIL b2b_accept: got %b want 11", {l2_addrok_r, l2_addrok_w});
    end
    tick();
    l2_req_r = 0; l2_req_w = 0;
    n_cmp++;
    if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b111) begin
      n_err++; $display("FAIL b2b_both_run: got %b want 111", {axi.arvalid, axi.awvalid, axi.wvalid});
    end
    axi.arready = 1; axi.awready = 1; axi.wready = 1;
    tick();
    axi.arready = 0; axi.awready = 0; axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'h77;
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    n_cmp++;
    if (l2_dataok !== 1'b1) begin n_err++; $display("FAIL b2b_rd_done: got %b want 1", l2_dataok); end
    k = 0;
    while (!axi.bready && k < 20) begin tick(); k++; end
    axi.wready = 0;
    n_cmp++;
    if (axi.bready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_timeout: got bready=%b want 1", axi.bready); end
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
  endtask

  task automatic test_rdy_stall();
    logic [LW-1:0] exp;
    l2_rdy = 0; l2_suc = 0; l2_addr_r = 32'h4000; l2_req_r = 1;
    tick();
    l2_req_r = 0; axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1; axi.rlast = (i == 7); axi.rdata = 32'h5A00_0000 | 32'(i);
      exp[i*32 +: 32] = 32'h5A00_0000 | 32'(i);
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({l2_dataok, l2_rline} !== {1'b0, exp}) begin
        n_err++; $display("FAIL stall_cycle%0d: got ok=%b line=%h want ok=0 line=%h", k, l2_dataok, l2_rline, exp);
      end
      tick();
    end
    l2_rdy = 1;
    #1;
    n_cmp++;
    if (l2_dataok !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", l2_dataok); end
    tick();
    n_cmp++;
    if ({l2_dataok, l2_rline} !== {1'b0, exp}) begin
      n_err++; $display("FAIL stall_after: got ok=%b line=%h want ok=0 line=%h", l2_dataok, l2_rline, exp);
    end
  endtask

  task automatic test_reset_and_bus_err();
    l2_rdy = 1; l2_suc = 0; l2_addr_r = 32'h7000; l2_req_r = 1;
    tick();
    l2_req_r = 0; axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int i = 0; i < 3; i++) begin
      axi.rvalid = 1; axi.rdata = 32'hBB00_0000 | 32'(i);
      tick();
    end
    axi.rdata = 32'hBB00_0003; rstn = 0;
    tick();
    rstn = 1; axi.rvalid = 0;
    #1;
    n_cmp++;
    if ({axi.rready, axi.arvalid} !== 2'b00) begin
      n_err++; $display("FAIL rst_mid_ctrl: got rready,arvalid=%b want 00", {axi.rready, axi.arvalid});
    end
    n_cmp++;
    if (l2_rline !== '0) begin n_err++; $display("FAIL rst_mid_rline: got %h want 0", l2_rline); end
    l2_req_r = 1;
    #1;
    n_cmp++;
    if (l2_addrok_r !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle: got %b want 1", l2_addrok_r); end
    l2_req_r = 0;
    #1;
    n_cmp++;
    if (bus_err !== 1'b0) begin n_err++; $display("FAIL err_clear_before: got %b want 0", bus_err); end
    l2_wline = '0; l2_wline[31:0] = 32'hDEAD_BEEF;
    l2_addr_w = 32'h5004; l2_suc = 1; l2_size = 2'd1; l2_wstrb = 4'b0011; l2_req_w = 1;
    tick();
    l2_req_w = 0; l2_suc = 0;
    #1;
    n_cmp++;
    if ({axi.awaddr, axi.awlen, axi.awsize, axi.wdata, axi.wstrb, axi.wlast} !==
        {32'h5004, 8'd0, 3'd1, 32'hDEAD_BEEF, 4'b0011, 1'b1}) begin
      n_err++;
      $display("FAIL suc_wr_fields: got a=%h len=%0d size=%0d d=%h strb=%b last=%b",
               axi.awaddr, axi.awlen, axi.awsize, axi.wdata, axi.wstrb, axi.wlast);
    end
    axi.awready = 1; axi.wready = 1;
    tick();
    axi.awready = 0; axi.wready = 0;
    n_cmp++;
    if (axi.bready !== 1'b1) begin n_err++; $display("FAIL suc_wr_resp: got bready=%b want 1", axi.bready); end
    axi.bvalid = 1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 0; axi.bresp = 2'b00;
    #1;
    n_cmp++;
    if (bus_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", bus_err); end
    tick();
    tick();
    n_cmp++;
    if (bus_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", bus_err); end
    rstn = 0;
    tick();
    rstn = 1;
    #1;
    n_cmp++;
    if (bus_err !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", bus_err); end
  endtask

  initial begin
    test_reset();
    test_line_read();
    test_suc_read();
    test_line_write();
    test_hazard();
    test_back_to_back();
    test_rdy_stall();
    test_reset_and_bus_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
